// File: rtl/ecc_gf11_pkg.sv
// rtl/ecc_gf11_pkg.sv - GF(11) constants, coordinate type, inverse table and point_halve states
package ecc_gf11_pkg;
    localparam int unsigned P = 11;
    localparam int unsigned A = 1;
    localparam int unsigned B = 6;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        CMP,
        DONE
    } state_t;

    // Entry i holds inv(i); index 10 is leftmost, inv(0)=0 by convention.
    localparam logic [10:0][3:0] INV_LUT = {
        4'd10, 4'd5, 4'd7, 4'd8, 4'd2, 4'd9, 4'd3, 4'd4, 4'd6, 4'd1, 4'd0
    };

    function automatic coord_t gf11_inv(input coord_t v);
        return (v > 4'd10) ? 4'd0 : INV_LUT[v];
    endfunction
endpackage

// File: rtl/point_halve_if.sv
// rtl/point_halve_if.sv - request/result bundle for the point halving engine
interface point_halve_if;
    logic              start;
    logic signed [8:0] q_x;
    logic signed [8:0] q_y;
    logic              busy;
    logic              done;
    logic              found;
    logic              invalid;
    logic signed [8:0] half_x;
    logic signed [8:0] half_y;

    modport master (
        output start, q_x, q_y,
        input  busy, done, found, invalid, half_x, half_y
    );

    modport slave (
        input  start, q_x, q_y,
        output busy, done, found, invalid, half_x, half_y
    );
endinterface

// File: rtl/gf11_mod.sv
// rtl/gf11_mod.sv - combinational reduction of a 12-bit unsigned value into 0..10
module gf11_mod
    import ecc_gf11_pkg::*;
(
    input  logic [11:0] a,
    output coord_t      r
);
    assign r = coord_t'(a % 12'(P));
endmodule

// File: rtl/point_halve.sv
// rtl/point_halve.sv - finds P with 2P = Q by scanning all GF(11) candidates through the doubling formula
// POINT_HALVE_EARLY_EXIT_EN: finish right after the first match instead of scanning all 121 candidates.
module point_halve
    import ecc_gf11_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    point_halve_if.slave bus
);
    state_t state, state_nxt;
    coord_t cx, cy, qx, qy, lam, hx, hy;
    logic   ok, found, invalid;
    logic   accept, q_bad, last, match;

    coord_t cx_sq, tan_num, two_cy, lam_d, y_sq, rhs, x3, y3;
    logic   ok_d;

    assign q_bad  = bus.q_x[8] || (bus.q_x[7:0] > 8'd10) || bus.q_y[8] || (bus.q_y[7:0] > 8'd10);
    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (cx == 4'd10) && (cy == 4'd10);

    // EVAL side: slope numerator/denominator and curve membership of (cx, cy)
    gf11_mod u_cx_sq  (.a(12'(cx) * 12'(cx)),                      .r(cx_sq));
    gf11_mod u_tan    (.a(12'd3 * 12'(cx_sq) + 12'(A)),            .r(tan_num));
    gf11_mod u_two_cy (.a(12'(cy) * 12'd2),                        .r(two_cy));
    gf11_mod u_lam    (.a(12'(tan_num) * 12'(gf11_inv(two_cy))),   .r(lam_d));
    gf11_mod u_y_sq   (.a(12'(cy) * 12'(cy)),                      .r(y_sq));
    gf11_mod u_rhs    (.a(12'(cx_sq) * 12'(cx) + 12'(cx) + 12'(B)), .r(rhs));

    assign ok_d = (y_sq == rhs) && (cy != 4'd0);

    // CMP side: subtractions are biased by P so the 12-bit operands never wrap
    gf11_mod u_x3 (.a(12'(lam) * 12'(lam) + 12'(2 * P) - 12'(cx) * 12'd2), .r(x3));
    gf11_mod u_y3 (.a(12'(lam) * (12'(cx) + 12'(P) - 12'(x3)) + 12'(P) - 12'(cy)), .r(y3));

    assign match = ok && (x3 == qx) && (y3 == qy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = q_bad ? DONE : EVAL;
            EVAL: state_nxt = CMP;
            CMP: begin
`ifdef POINT_HALVE_EARLY_EXIT_EN
                state_nxt = (match || last) ? DONE : EVAL;
`else
                state_nxt = last ? DONE : EVAL;
`endif
            end
            DONE: state_nxt = accept ? (q_bad ? DONE : EVAL) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qx      <= '0;
            qy      <= '0;
            cx      <= '0;
            cy      <= '0;
            lam     <= '0;
            ok      <= 1'b0;
            hx      <= '0;
            hy      <= '0;
            found   <= 1'b0;
            invalid <= 1'b0;
        end else if (accept) begin
            qx      <= coord_t'(bus.q_x[3:0]);
            qy      <= coord_t'(bus.q_y[3:0]);
            cx      <= '0;
            cy      <= '0;
            hx      <= '0;
            hy      <= '0;
            found   <= 1'b0;
            invalid <= q_bad;
        end else if (state == EVAL) begin
            lam <= lam_d;
            ok  <= ok_d;
        end else if (state == CMP) begin
            // Only the lowest-index match is reported
            if (match && !found) begin
                hx    <= cx;
                hy    <= cy;
                found <= 1'b1;
            end
            if (cy == 4'd10) begin
                cy <= '0;
                cx <= cx + 4'd1;
            end else begin
                cy <= cy + 4'd1;
            end
        end
    end

    assign bus.busy    = (state == EVAL) || (state == CMP);
    assign bus.done    = (state == DONE);
    assign bus.found   = found;
    assign bus.invalid = invalid;
    assign bus.half_x  = {5'd0, hx};
    assign bus.half_y  = {5'd0, hy};
endmodule

// File: tb/tb_point_halve.sv
// tb/tb_point_halve.sv - directed bench for point_halve against a brute-force curve-arithmetic model
module tb_point_halve;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    point_halve_if bus ();

    point_halve dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int md(input int v);
        return ((v % 11) + 11) % 11;
    endfunction

    // Double every point on y^2 = x^3 + x + 6 in index order; keep the first hit.
    function automatic void model(input int x, input int y, output bit f, output int hx,
                                  output int hy, output int k, output bit inv, output int cyc);
        f = 0; hx = 0; hy = 0; k = -1;
        inv = (x < 0) || (x > 10) || (y < 0) || (y > 10);
        if (inv) begin
            cyc = 1;
            return;
        end
        for (int px = 0; px < 11; px++) begin
            for (int py = 1; py < 11; py++) begin
                int d, iv, lam, x3, y3;
                if (md(py * py) != md(px * px * px + px + 6)) continue;
                d = md(2 * py);
                iv = 0;
                for (int t = 1; t < 11; t++) if (md(d * t) == 1) iv = t;
                lam = md((3 * px * px + 1) * iv);
                x3 = md(lam * lam - 2 * px);
                y3 = md(lam * (px - x3) - py);
                if (!f && x3 == x && y3 == y) begin
                    f = 1; hx = px; hy = py; k = 11 * px + py;
                end
            end
        end
`ifdef POINT_HALVE_EARLY_EXIT_EN
        cyc = f ? 3 + 2 * k : 243;
`else
        cyc = 243;
`endif
    endfunction

    task automatic launch(input int x, input int y);
        bus.q_x   = x[8:0];
        bus.q_y   = y[8:0];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Entered at cycle 1 of a scan; optionally pulses an ignored start at ignore_at.
    task automatic follow(input int x, input int y, input int ignore_at, input bit chain,
                          input string tag);
        bit mf, minv;
        int mhx, mhy, mk, mcyc, first;
        bit bad_busy;
        model(x, y, mf, mhx, mhy, mk, minv, mcyc);
        first = -1;
        bad_busy = 0;
        for (int cyc = 1; cyc <= 260; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            bus.start = 1'b0;
            if (cyc == ignore_at) begin
                bus.start = 1'b1;
                bus.q_x   = 9'sd0;
                bus.q_y   = 9'sd0;
            end
            if (bus.done) begin
                first = cyc;
                break;
            end
            if (!bus.busy) bad_busy = 1;
        end
        check({tag, "_done_cycle"}, first, mcyc);
        check({tag, "_busy_window"}, int'(bad_busy), 0);
        check({tag, "_found"}, int'(bus.found), int'(mf));
        check({tag, "_invalid"}, int'(bus.invalid), int'(minv));
        check({tag, "_half_x"}, int'(bus.half_x), mhx);
        check({tag, "_half_y"}, int'(bus.half_y), mhy);
        if (!chain) begin
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, int'(bus.done), 0);
            check({tag, "_idle_busy"}, int'(bus.busy), 0);
            check({tag, "_hold_found"}, int'(bus.found), int'(mf));
            check({tag, "_hold_half_x"}, int'(bus.half_x), mhx);
        end
    endtask

    initial begin
        bit f, inv;
        int hx, hy, k, cyc;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.q_x = '0;
        bus.q_y = '0;

        model(5, 2, f, hx, hy, k, inv, cyc);
        check("pin_52_found", int'(f), 1);
        check("pin_52_x", hx, 2);
        check("pin_52_y", hy, 7);
        check("pin_52_k", k, 29);
        model(5, 9, f, hx, hy, k, inv, cyc);
        check("pin_59_x", hx, 2);
        check("pin_59_y", hy, 4);
        check("pin_59_k", k, 26);
        model(0, 0, f, hx, hy, k, inv, cyc);
        check("pin_00_found", int'(f), 0);
        check("pin_00_cycle", cyc, 243);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_found", int'(bus.found), 0);
        check("rst_invalid", int'(bus.invalid), 0);
        check("rst_half_x", int'(bus.half_x), 0);
        check("rst_half_y", int'(bus.half_y), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(5, 2);  follow(5, 2, 0, 0, "q52");
        launch(5, 9);  follow(5, 9, 0, 0, "q59");
        launch(0, 0);  follow(0, 0, 0, 0, "q00");
        launch(11, 3); follow(11, 3, 0, 0, "qx11");
        launch(4, -1); follow(4, -1, 0, 0, "qyneg");
        launch(8, 3);  follow(8, 3, 0, 0, "q83");
        launch(10, 9); follow(10, 9, 0, 0, "q109");

        launch(5, 2);
        bus.start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("pre_reset_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_found", int'(bus.found), 0);
        check("mid_rst_half_x", int'(bus.half_x), 0);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", int'(bus.busy), 0);
        launch(5, 2);  follow(5, 2, 0, 0, "post_reset");

        launch(5, 9);  follow(5, 9, 10, 1, "ignored");
        bus.q_x   = 9'sd5;
        bus.q_y   = 9'sd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("chain_busy", int'(bus.busy), 1);
        check("chain_found_clr", int'(bus.found), 0);
        check("chain_half_x_clr", int'(bus.half_x), 0);
        check("chain_half_y_clr", int'(bus.half_y), 0);
        follow(5, 2, 0, 0, "chain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
